add_arbiter: RTL and testbench



---
 rtl/add_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_add_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one asynchronous bundled-data adder among N
// clocked requesters through a four-phase req/fin handshake.
module add_arbiter #(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_in,
    input  logic [N*WIDTH-1:0]   a_in,
    input  logic [N*WIDTH-1:0]   b_in,
    output logic [N-1:0]         done,
    output logic [WIDTH-1:0]     sum_out,
    output logic                 cout_out,
    output logic                 err,
    output logic                 busy,
    output logic                 add_req,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic                 add_fin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_FIN = 3'd2,
        S_RELEASE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]     pick_s;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_p_q, err_p_d;
    logic [N-1:0]      done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              add_req_q, add_req_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic              sync1_q, fin_s_q;
    logic [1:0]        vld_q;

    // First requester set after 'last', wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [IW-1:0] last);
        logic found;
        int   idx;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                rr_pick = IW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign pick_s = rr_pick(req_in, last_q);

    // Two-flop synchroniser for add_fin. vld_q blocks grants until the
    // synchroniser has refilled after reset, since its cleared flops say
    // nothing about a stale fin from an aborted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            fin_s_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= add_fin;
            fin_s_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        err_p_d   = err_p_q;
        done_d    = {N{1'b0}};
        err_d     = 1'b0;
        sum_d     = sum_q;
        cout_d    = cout_q;
        add_req_d = add_req_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        case (state_q)
            S_IDLE: begin
                if (vld_q[1] && !fin_s_q && (|req_in)) begin
                    gnt_d   = pick_s;
                    last_d  = pick_s;
                    add_a_d = a_in[int'(pick_s)*WIDTH +: WIDTH];
                    add_b_d = b_in[int'(pick_s)*WIDTH +: WIDTH];
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d     = {CW{1'b0}};
                add_req_d = 1'b1;
                state_d   = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                cnt_d = cnt_q + CW'(1);
                if (fin_s_q) begin
                    sum_d     = add_s;
                    cout_d    = add_cout;
                    err_p_d   = 1'b0;
                    add_req_d = 1'b0;
                    state_d   = S_RELEASE;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    sum_d     = {WIDTH{1'b0}};
                    cout_d    = 1'b0;
                    err_p_d   = 1'b1;
                    add_req_d = 1'b0;
                    state_d   = S_RELEASE;
                end else begin
                    state_d = S_WAIT_FIN;
                end
            end
            S_RELEASE: begin
                if (!fin_s_q) begin
                    done_d  = {{(N-1){1'b0}}, 1'b1} << gnt_q;
                    err_d   = err_p_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                add_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= IW'(N - 1);
            gnt_q     <= {IW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            err_p_q   <= 1'b0;
            done_q    <= {N{1'b0}};
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            sum_q     <= {WIDTH{1'b0}};
            cout_q    <= 1'b0;
            add_req_q <= 1'b0;
            add_a_q   <= {WIDTH{1'b0}};
            add_b_q   <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            err_p_q   <= err_p_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            add_req_q <= add_req_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign sum_out  = sum_q;
    assign cout_out = cout_q;
    assign add_req  = add_req_q;
    assign add_a    = add_a_q;
    assign add_b    = add_b_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with a behavioural four-phase adder and a
// queue of expected completions checked as each done pulse appears.
module tb_add_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_in;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   done;
    logic [W-1:0]   sum_out;
    logic           cout_out, err, busy, add_req;
    logic [W-1:0]   add_a, add_b;
    logic           add_fin;
    logic [W-1:0]   add_s;
    logic           add_cout;

    always #5 clk = ~clk;

    add_arbiter #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .a_in(a_in), .b_in(b_in),
        .done(done), .sum_out(sum_out), .cout_out(cout_out), .err(err),
        .busy(busy), .add_req(add_req), .add_a(add_a), .add_b(add_b),
        .add_fin(add_fin), .add_s(add_s), .add_cout(add_cout)
    );

    // Adder model: fin follows req by dly edges, with override knobs.
    logic [7:0] hist = 8'h00;
    int         dly = 3;
    logic       never_fin = 1'b0;
    logic       force_fin = 1'b0;
    always @(posedge clk) hist <= {hist[6:0], add_req};
    assign add_fin = force_fin | (!never_fin & hist[dly-1]);
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

    typedef struct {
        logic [N-1:0] d;
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] d, input logic [W-1:0] s,
                            input logic c, input logic e);
        exp_t x;
        x.d = d; x.s = s; x.c = c; x.e = e;
        sbq.push_back(x);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    // drop: 0 keep requests, 1 drop own bit, 2 drop all
    task automatic wait_done(input string tag, input int drop);
        int   n;
        exp_t x;
        n = 0;
        while (done == '0 && n < 80) begin
            tick();
            n++;
        end
        if (done == '0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_done expected=done_pulse", tag);
        end else if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected observed=%0h expected=no_done", tag, done);
        end else begin
            x = sbq.pop_front();
            check({tag, "_done"}, 64'(done), 64'(x.d));
            check({tag, "_sum"}, 64'(sum_out), 64'(x.s));
            check({tag, "_cout"}, 64'(cout_out), 64'(x.c));
            check({tag, "_err"}, 64'(err), 64'(x.e));
            check({tag, "_req_low"}, 64'(add_req), 64'(0));
            if (drop == 1) req_in = req_in & ~done;
            if (drop == 2) req_in = '0;
            tick();
            check({tag, "_pulse_1cyc"}, 64'(done), 64'(0));
            check({tag, "_busy_fall"}, 64'(busy), 64'(0));
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_in = '0; a_in = '0; b_in = '0;

        // Reset values
        repeat (3) tick();
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_add_req", 64'(add_req), 64'(0));
        check("rst_add_a", 64'(add_a), 64'(0));
        check("rst_add_b", 64'(add_b), 64'(0));
        check("rst_sum", 64'({cout_out, sum_out}), 64'(0));
        rst = 1'b0;
        repeat (3) tick();

        // Single request with four-phase handshake
        set_ops(0, 32'h0000_0005, 32'h0000_0003);
        req_in = 4'b0001;
        push_exp(4'b0001, 32'd8, 1'b0, 1'b0);
        tick();
        check("single_launch_busy", 64'(busy), 64'(1));
        check("single_launch_req", 64'(add_req), 64'(0));
        check("single_add_a", 64'(add_a), 64'(5));
        set_ops(0, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        check("single_req_rise", 64'(add_req), 64'(1));
        n = 0;
        while (!add_fin && n < 20) begin tick(); n++; end
        check("single_fin_seen", 64'(add_fin), 64'(1));
        wait_done("single", 1);
        check("single_fin_low", 64'(add_fin), 64'(0));

        // Carry out and wrap
        set_ops(2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_in = 4'b0100;
        push_exp(4'b0100, 32'd0, 1'b1, 1'b0);
        wait_done("carry", 1);

        // Contention from a fresh reset: order 0,1,2,3,0
        do_reset(2);
        repeat (3) tick();
        for (int i = 0; i < N; i++) set_ops(i, W'(i), W'(i));
        for (int i = 0; i < 5; i++) push_exp(4'b0001 << (i % N), W'(2 * (i % N)), 1'b0, 1'b0);
        req_in = 4'b1111;
        for (int i = 0; i < 4; i++) wait_done("contend", 0);
        wait_done("contend_last", 2);

        // Timeout: adder never finishes
        never_fin = 1'b1;
        set_ops(3, 32'd7, 32'd9);
        req_in = 4'b1000;
        push_exp(4'b1000, 32'd0, 1'b0, 1'b1);
        n = 0;
        while (!add_req && n < 20) begin tick(); n++; end
        n = 0;
        while (add_req && n < 60) begin tick(); n++; end
        check("timeout_req_cycles", 64'(n), 64'(TO));
        wait_done("timeout", 1);
        never_fin = 1'b0;
        repeat (6) tick();

        // Reset mid-operation with a late fin
        set_ops(0, 32'd10, 32'd20);
        set_ops(1, 32'd1, 32'd1);
        req_in = 4'b0010;
        n = 0;
        while (!add_req && n < 20) begin tick(); n++; end
        check("midrst_req_high", 64'(add_req), 64'(1));
        force_fin = 1'b1;
        rst = 1'b1;
        tick();
        check("midrst_req_drop", 64'(add_req), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        req_in = 4'b0011;
        push_exp(4'b0001, 32'd30, 1'b0, 1'b0);
        push_exp(4'b0010, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_hold_busy", 64'(busy), 64'(0));
        end
        force_fin = 1'b0;
        tick();
        check("midrst_sync1_busy", 64'(busy), 64'(0));
        tick();
        check("midrst_sync2_busy", 64'(busy), 64'(0));
        tick();
        check("midrst_grant_busy", 64'(busy), 64'(1));
        wait_done("midrst_r0", 1);
        wait_done("midrst_r1", 1);
        repeat (4) tick();

        // Stale fin held through the end of reset
        force_fin = 1'b1;
        do_reset(3);
        set_ops(2, 32'd3, 32'd4);
        req_in = 4'b0100;
        push_exp(4'b0100, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stale_busy", 64'(busy), 64'(0));
        end
        force_fin = 1'b0;
        wait_done("stale", 1);
        check("sb_empty", 64'(sbq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
